// File: rtl/responder_pkg.sv
// Shared types for the quiz responder: arbitration states,
// player count and winner-encoding helpers.
package responder_pkg;

   localparam int N_PLAYERS = 4;
   localparam int ID_W      = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Keep only the lowest set bit: fixed priority, player 0 highest.
   function automatic logic [N_PLAYERS-1:0] first_one(
      input logic [N_PLAYERS-1:0] v
   );
      logic [N_PLAYERS-1:0] r;
      r = '0;
      for (int i = N_PLAYERS - 1; i >= 0; i--) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [ID_W-1:0] onehot_id(
      input logic [N_PLAYERS-1:0] v
   );
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (v[i]) id = ID_W'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/responder_debounce.sv
// One button lane: 2-flop synchronizer, counting debouncer
// and registered rising-edge detect.
module responder_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic       sync1;
   logic       sync2;
   logic       db;
   logic       db_q;
   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         db    <= 1'b0;
         db_q  <= 1'b0;
         press <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         db_q  <= db;
         press <= db & ~db_q;
         // Any cycle agreeing with db restarts the stability count.
         if (sync2 != db) begin
            if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
               db  <= sync2;
               cnt <= '0;
            end else begin
               cnt <= cnt + 8'd1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/responder_buzzer_arbiter.sv
// Buzzer front end: four debounced lanes, first-press lock
// with fixed priority, and sticky early-press foul flags.
module responder_buzzer_arbiter
   import responder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_PLAYERS-1:0] btn,
   input  logic                 arm,
   input  logic                 clear,
   output logic                 touch,
   output logic [N_PLAYERS-1:0] winner,
   output logic [ID_W-1:0]      winner_id,
   output logic [N_PLAYERS-1:0] foul
);

   logic [N_PLAYERS-1:0] press;

   for (genvar i = 0; i < N_PLAYERS; i++) begin : g_lane
      responder_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .btn  (btn[i]),
         .press(press[i])
      );
   end

   state_t               state_q;
   state_t               state_d;
   logic                 touch_d;
   logic [N_PLAYERS-1:0] winner_d;
   logic [ID_W-1:0]      winner_id_d;
   logic [N_PLAYERS-1:0] foul_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         touch     <= 1'b0;
         winner    <= '0;
         winner_id <= '0;
         foul      <= '0;
      end else begin
         state_q   <= state_d;
         touch     <= touch_d;
         winner    <= winner_d;
         winner_id <= winner_id_d;
         foul      <= foul_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            LOCKED:  state_d = LOCKED;
            ARMED: begin
               if (|press)    state_d = LOCKED;
               else if (!arm) state_d = IDLE;
            end
            IDLE:    if (arm) state_d = ARMED;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      touch_d     = touch;
      winner_d    = winner;
      winner_id_d = winner_id;
      foul_d      = foul;
      if (clear) begin
         touch_d     = 1'b0;
         winner_d    = '0;
         winner_id_d = '0;
         foul_d      = '0;
      end else begin
         unique case (state_q)
            ARMED: begin
               if (|press) begin
                  touch_d     = 1'b1;
                  winner_d    = first_one(press);
                  winner_id_d = onehot_id(first_one(press));
               end
            end
            // A press in the cycle arm first rises still lands here.
            IDLE:    foul_d = foul | press;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_responder_buzzer_arbiter.sv
// Bench for responder_buzzer_arbiter: per-edge reference model
// plus directed scenarios with hand-computed expectations.
module tb_responder_buzzer_arbiter;
   import responder_pkg::*;

   localparam int N     = 4;
   localparam int DEPTH = 4096;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic       arm;
   logic       clear;
   logic       touch;
   logic [3:0] winner;
   logic [1:0] winner_id;
   logic [3:0] foul;

   responder_buzzer_arbiter #(
      .DEBOUNCE_CYCLES(N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn),
      .arm      (arm),
      .clear    (clear),
      .touch    (touch),
      .winner   (winner),
      .winner_id(winner_id),
      .foul     (foul)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: raw samples and debounced levels indexed by edge number.
   bit   hist[4][DEPTH];
   bit   dbh[4][DEPTH];
   int   t = 16;
   bit   m_ok = 1'b0;
   int   m_state = 0;
   logic       m_touch = 1'b0;
   logic [3:0] m_win = '0;
   logic [1:0] m_id = '0;
   logic [3:0] m_foul = '0;

   always @(posedge clk) begin : model
      logic [3:0] p;
      bit         flip;
      if (t >= DEPTH - 2) begin
         $display("FAIL model_depth t=%0d limit=%0d", t, DEPTH - 2);
         $fatal(1);
      end
      t = t + 1;
      p = '0;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            for (int k = 0; k <= N + 1; k++) hist[i][t-k] = 1'b0;
            dbh[i][t]   = 1'b0;
            dbh[i][t-1] = 1'b0;
         end
         m_state = 0;
         m_touch = 1'b0;
         m_win   = '0;
         m_id    = '0;
         m_foul  = '0;
         m_ok    = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            hist[i][t] = btn[i];
            // Flip when the last N synchronized samples all disagree.
            flip = 1'b1;
            for (int k = 2; k <= N + 1; k++)
               if (hist[i][t-k] == dbh[i][t-1]) flip = 1'b0;
            dbh[i][t] = flip ? ~dbh[i][t-1] : dbh[i][t-1];
            p[i] = dbh[i][t-2] & ~dbh[i][t-3];
         end
         if (clear) begin
            m_state = 0;
            m_touch = 1'b0;
            m_win   = '0;
            m_id    = '0;
            m_foul  = '0;
         end else if (m_state == 2) begin
            m_state = 2;
         end else if (m_state == 1) begin
            if (p != 0) begin
               m_state = 2;
               m_touch = 1'b1;
               for (int i = 3; i >= 0; i--) begin
                  if (p[i]) begin
                     m_win = 4'(1 << i);
                     m_id  = 2'(i);
                  end
               end
            end else if (!arm) begin
               m_state = 0;
            end
         end else begin
            m_foul = m_foul | p;
            if (arm) m_state = 1;
         end
      end
      #1;
      if (m_ok) begin
         total++;
         if (touch !== m_touch || winner !== m_win ||
             winner_id !== m_id || foul !== m_foul) begin
            bad++;
            $display("FAIL model_cmp t=%0d got t=%b w=%b id=%0d f=%b want t=%b w=%b id=%0d f=%b",
                     t, touch, winner, winner_id, foul,
                     m_touch, m_win, m_id, m_foul);
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear();
      @(negedge clk) clear = 1'b1;
      @(negedge clk) clear = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      arm   = 1'b0;
      clear = 1'b0;
      btn   = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_touch", 8'(touch), 8'h0);
      chk("rst_winner", 8'(winner), 8'h0);
      chk("rst_foul", 8'(foul), 8'h0);
      @(negedge clk) rst = 1'b0;
      wait_n(15);
      chk("held_touch", 8'(touch), 8'h0);
      chk("held_foul", 8'(foul), 8'hf);
      pulse_clear();
      chk("clr_foul", 8'(foul), 8'h0);
      btn = 4'b0000;
      wait_n(12);

      // Single clean press by player 2, then a late press by player 0.
      arm = 1'b1;
      wait_n(2);
      @(negedge clk) btn = 4'b0100;
      repeat (7) @(posedge clk);
      #1 chk("p2_edge6_touch", 8'(touch), 8'h0);
      @(posedge clk);
      #1;
      chk("p2_edge7_touch", 8'(touch), 8'h1);
      chk("p2_winner", 8'(winner), 8'h04);
      chk("p2_id", 8'(winner_id), 8'h2);
      @(negedge clk) btn = 4'b0101;
      wait_n(12);
      chk("p2_late_p0", 8'(winner), 8'h04);
      pulse_clear();
      arm = 1'b0;
      btn = 4'b0000;
      wait_n(12);

      // Players 1 and 3 on the same cycle.
      arm = 1'b1;
      wait_n(2);
      btn = 4'b1010;
      wait_n(12);
      chk("tie_winner", 8'(winner), 8'h02);
      chk("tie_id", 8'(winner_id), 8'h1);
      pulse_clear();
      arm = 1'b0;
      btn = 4'b0000;
      wait_n(12);

      // Early press fouls, then the same player wins once armed.
      btn = 4'b0001;
      wait_n(12);
      chk("foul_set", 8'(foul), 8'h01);
      chk("foul_touch", 8'(touch), 8'h0);
      btn = 4'b0000;
      wait_n(12);
      arm = 1'b1;
      wait_n(2);
      btn = 4'b0001;
      wait_n(12);
      chk("foul_win", 8'(winner), 8'h01);
      chk("foul_kept", 8'(foul), 8'h01);
      pulse_clear();
      arm = 1'b0;
      btn = 4'b0000;
      wait_n(12);

      // Three 3-cycle glitches must never pass the debouncer.
      arm = 1'b1;
      wait_n(2);
      for (int g = 0; g < 3; g++) begin
         btn = 4'b0010;
         wait_n(3);
         btn = 4'b0000;
         wait_n(3);
      end
      wait_n(10);
      chk("glitch_touch", 8'(touch), 8'h0);
      arm = 1'b0;
      wait_n(4);

      // Lock on player 3, clear while still held.
      arm = 1'b1;
      wait_n(2);
      btn = 4'b1000;
      wait_n(12);
      chk("p3_lock", 8'(winner), 8'h08);
      @(negedge clk) clear = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_touch", 8'(touch), 8'h0);
      chk("clr_winner", 8'(winner), 8'h0);
      chk("clr_id", 8'(winner_id), 8'h0);
      @(negedge clk) clear = 1'b0;
      wait_n(20);
      chk("held_no_relock", 8'(touch), 8'h0);
      btn = 4'b0000;
      wait_n(12);
      chk("release_touch", 8'(touch), 8'h0);
      btn = 4'b1000;
      wait_n(12);
      chk("repress_touch", 8'(touch), 8'h1);
      chk("repress_id", 8'(winner_id), 8'h3);

      wait_n(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
